// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared types and constants for the 2-input gate sweep controller and its
// expected-value lookup.
package gate_sweep_ctrl_pkg;

    localparam int unsigned SEL_W    = 3;
    localparam int unsigned VEC_W    = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned SETTLE_W = 8;

    localparam logic [SEL_W-1:0] GATE_AND  = 3'd0;
    localparam logic [SEL_W-1:0] GATE_OR   = 3'd1;
    localparam logic [SEL_W-1:0] GATE_XOR  = 3'd2;
    localparam logic [SEL_W-1:0] GATE_NAND = 3'd3;
    localparam logic [SEL_W-1:0] GATE_NOR  = 3'd4;
    localparam logic [SEL_W-1:0] GATE_XNOR = 3'd5;

    // Truth tables: bit v is the gate output for vector v = {in0, in1}
    localparam logic [3:0] MASK_AND  = 4'b1000;
    localparam logic [3:0] MASK_OR   = 4'b1110;
    localparam logic [3:0] MASK_XOR  = 4'b0110;
    localparam logic [3:0] MASK_NAND = 4'b0111;
    localparam logic [3:0] MASK_NOR  = 4'b0001;
    localparam logic [3:0] MASK_XNOR = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic             pass;
        logic [CNT_W-1:0] fail_cnt;
        logic [VEC_W-1:0] first_fail_vec;
        logic             first_fail_valid;
        logic             sel_err;
    } result_t;

    function automatic logic is_running(input state_t s);
        return (s == ST_APPLY) || (s == ST_WAIT) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/gate_expect_lut.sv
// Expected gate output for a (gate code, input vector) pair, plus a flag
// telling whether the gate code names a supported function.
module gate_expect_lut
    import gate_sweep_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0] gate_sel,
    input  logic [VEC_W-1:0] vec,
    output logic             expected_c,
    output logic             sel_valid_c
);

    logic [3:0] mask;

    always_comb begin
        mask        = 4'b0000;
        sel_valid_c = 1'b1;
        case (gate_sel)
            GATE_AND:  mask = MASK_AND;
            GATE_OR:   mask = MASK_OR;
            GATE_XOR:  mask = MASK_XOR;
            GATE_NAND: mask = MASK_NAND;
            GATE_NOR:  mask = MASK_NOR;
            GATE_XNOR: mask = MASK_XNOR;
            default:   sel_valid_c = 1'b0;
        endcase
        expected_c = mask[vec];
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives a 2-input gate through vectors 00,01,10,11, waits for it to settle,
// and scores each output against the selected truth table.
module gate_sweep_ctrl
    import gate_sweep_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SEL_W-1:0] gate_sel,
    input  logic             gate_out,
    output logic             in0,
    output logic             in1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid,
    output logic             sel_err
);

    localparam bit                  NO_WAIT     = (SETTLE_CYCLES == 0);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        NO_WAIT ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    result_t             res_q, res_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                in0_q, in0_d, in1_q, in1_d;

    logic [SEL_W-1:0]    lut_sel;
    logic                expected_c, sel_valid_c;
    logic                abort_run;

    // Validity is judged on the live code in IDLE; expectations use the latched code.
    assign lut_sel   = (state_q == ST_IDLE) ? gate_sel : sel_q;
    assign abort_run = abort && is_running(state_q);

    gate_expect_lut u_lut (
        .gate_sel    (lut_sel),
        .vec         (vec_q),
        .expected_c  (expected_c),
        .sel_valid_c (sel_valid_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = sel_valid_c ? ST_APPLY : ST_DONE;
            ST_APPLY: state_d = NO_WAIT ? ST_CHECK : ST_WAIT;
            ST_WAIT:  if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
            ST_CHECK: state_d = (vec_q == VEC_W'(3)) ? ST_DONE : ST_APPLY;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_run) state_d = ST_IDLE;
    end

    // Next values of the datapath and registered outputs, keyed off state_d
    // so outputs line up with the state they describe.
    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        res_d    = res_q;
        case (state_q)
            ST_IDLE: if (start) begin
                if (sel_valid_c) begin
                    sel_d = gate_sel;
                    vec_d = '0;
                    res_d = '0;
                end else begin
                    res_d.sel_err = 1'b1;
                    res_d.pass    = 1'b0;
                end
            end
            ST_APPLY: settle_d = '0;
            ST_WAIT:  settle_d = settle_q + SETTLE_W'(1);
            ST_CHECK: if (!abort) begin
                if (gate_out != expected_c) begin
                    res_d.fail_cnt = res_q.fail_cnt + CNT_W'(1);
                    if (!res_q.first_fail_valid) begin
                        res_d.first_fail_vec   = vec_q;
                        res_d.first_fail_valid = 1'b1;
                    end
                end
                if (vec_q != VEC_W'(3)) vec_d = vec_q + VEC_W'(1);
            end
            default: ;
        endcase
        if (abort_run) res_d.pass = 1'b0;
        if (state_d == ST_DONE) res_d.pass = (res_d.fail_cnt == '0) && !res_d.sel_err;
        busy_d = is_running(state_d);
        done_d = (state_d == ST_DONE);
        in0_d  = busy_d & vec_d[1];
        in1_d  = busy_d & vec_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            settle_q <= '0;
            sel_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            in0_q    <= 1'b0;
            in1_q    <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
        end
    end

    assign in0              = in0_q;
    assign in1              = in1_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = res_q.pass;
    assign fail_cnt         = res_q.fail_cnt;
    assign first_fail_vec   = res_q.first_fail_vec;
    assign first_fail_valid = res_q.first_fail_valid;
    assign sel_err          = res_q.sel_err;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: one instance with the default settle time and one
// with no settle time, each driving a configurable behavioural gate.
module tb_gate_sweep_ctrl;

    localparam int S_A = 2;
    localparam int S_B = 0;

    typedef struct packed {
        logic       in0;
        logic       in1;
        logic       busy;
        logic       done;
        logic       pass;
        logic [2:0] fcnt;
        logic [1:0] ffv;
        logic       ffval;
        logic       serr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [2:0] sel_a = 3'd0, sel_b = 3'd0;
    int         gut_a = 1, gut_b = 1;
    logic       gout_a, gout_b;
    logic       in0_a, in1_a, busy_a, done_a, pass_a, ffval_a, serr_a;
    logic       in0_b, in1_b, busy_b, done_b, pass_b, ffval_b, serr_b;
    logic [2:0] fcnt_a, fcnt_b;
    logic [1:0] ffv_a, ffv_b;

    int total = 0;
    int bad = 0;

    // Gate kinds 0..5 follow the gate codes; +8 inverts the output.
    function automatic logic gate_fn(input int kind, input logic a, input logic b);
        logic r;
        case (kind % 8)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~(a & b);
            4: r = ~(a | b);
            5: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r ^ (kind >= 8);
    endfunction

    assign gout_a = gate_fn(gut_a, in0_a, in1_a);
    assign gout_b = gate_fn(gut_b, in0_b, in1_b);

    gate_sweep_ctrl #(.SETTLE_CYCLES(S_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .gate_sel(sel_a), .gate_out(gout_a), .in0(in0_a), .in1(in1_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_cnt(fcnt_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_a), .sel_err(serr_a)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(S_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .gate_sel(sel_b), .gate_out(gout_b), .in0(in0_b), .in1(in1_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_cnt(fcnt_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_b), .sel_err(serr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int w, output obs_t o);
        if (w == 0) o = '{in0_a, in1_a, busy_a, done_a, pass_a, fcnt_a, ffv_a, ffval_a, serr_a};
        else        o = '{in0_b, in1_b, busy_b, done_b, pass_b, fcnt_b, ffv_b, ffval_b, serr_b};
    endtask

    task automatic drv(input int w, input logic st, input logic ab, input logic [2:0] sel);
        if (w == 0) begin start_a = st; abort_a = ab; sel_a = sel; end
        else        begin start_b = st; abort_b = ab; sel_b = sel; end
    endtask

    // One sweep from a start pulse, scored against a model built from the
    // truth tables; abort_at/repulse_at are sample indices after acceptance.
    task automatic run_sweep(input int w, input logic [2:0] sel, input int gut,
                             input int abort_at, input int repulse_at, input bit abort_with_start);
        int s, per, lat, nchk, idx, exp_fail, exp_ffv;
        int in_bad, busy_bad, done_bad;
        bit valid, exp_ffval, exp_pass, live, edone;
        logic ein0, ein1;
        logic [2:0] cur_sel;
        obs_t o, od;
        s     = (w == 0) ? S_A : S_B;
        per   = s + 2;
        valid = (sel < 3'd6);
        lat   = valid ? 4 * per + 1 : 1;
        nchk  = (abort_at > 0) ? (abort_at - 1) / per : 4;
        exp_fail = 0; exp_ffv = 0; exp_ffval = 0;
        for (int v = 0; v < nchk; v++) begin
            if (gate_fn(gut, v[1], v[0]) != gate_fn(int'(sel), v[1], v[0])) begin
                if (!exp_ffval) exp_ffv = v;
                exp_ffval = 1;
                exp_fail++;
            end
        end
        exp_pass = valid && (exp_fail == 0) && (abort_at == 0);
        if (w == 0) gut_a = gut; else gut_b = gut;
        cur_sel = sel;
        in_bad = 0; busy_bad = 0; done_bad = 0; od = '0; o = '0;
        @(negedge clk);
        drv(w, 1'b1, abort_with_start, sel);
        @(posedge clk);
        for (int k = 1; k <= lat + 3; k++) begin
            if (k > 1) @(posedge clk);
            #1;
            sample(w, o);
            live  = valid && ((abort_at > 0) ? (k <= abort_at) : (k < lat));
            idx   = (k - 1) / per;
            ein0  = live ? idx[1] : 1'b0;
            ein1  = live ? idx[0] : 1'b0;
            edone = (abort_at == 0) && (k == lat);
            if (o.busy !== live) busy_bad++;
            if (o.in0 !== ein0 || o.in1 !== ein1) in_bad++;
            if (o.done !== edone) done_bad++;
            if (k == lat) od = o;
            if (k == repulse_at) cur_sel = 3'd4;
            drv(w, k == repulse_at, k == abort_at, cur_sel);
        end
        chk("busy_profile_errs", busy_bad, 0);
        chk("in_vector_errs", in_bad, 0);
        chk("done_timing_errs", done_bad, 0);
        if (abort_at > 0) begin
            chk("abort_fail_cnt", o.fcnt, exp_fail);
            chk("abort_ffvalid", o.ffval, exp_ffval);
            chk("abort_pass", o.pass, 0);
        end else if (valid) begin
            chk("done_pass", od.pass, exp_pass);
            chk("done_fail_cnt", od.fcnt, exp_fail);
            chk("done_ffvalid", od.ffval, exp_ffval);
            if (exp_ffval) chk("done_ffvec", od.ffv, exp_ffv);
            chk("done_sel_err", od.serr, 0);
            chk("pass_held", o.pass, exp_pass);
        end else begin
            chk("inv_sel_err", od.serr, 1);
            chk("inv_pass", od.pass, 0);
            chk("inv_sel_err_held", o.serr, 1);
        end
    endtask

    initial begin
        obs_t o;
        int w, per, lat, ab_at, rp_at, dcount;
        logic [2:0] sel;
        repeat (3) @(posedge clk);
        #1;
        sample(0, o); chk("reset_a", 32'(o), 0);
        sample(1, o); chk("reset_b", 32'(o), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sample(0, o); chk("post_reset_a", 32'(o), 0);

        run_sweep(0, 3'd1, 1, 0, 0, 0);    // OR vs OR gate
        run_sweep(0, 3'd0, 1, 0, 0, 0);    // AND vs OR gate: fails on 01,10
        run_sweep(0, 3'd7, 1, 0, 0, 0);    // invalid code
        run_sweep(0, 3'd6, 1, 0, 0, 0);
        run_sweep(0, 3'd0, 1, 10, 0, 0);   // abort in WAIT of vector 2
        run_sweep(0, 3'd1, 1, 0, 0, 0);
        run_sweep(0, 3'd1, 1, 0, 6, 0);    // restart mid-sweep with NOR on gate_sel
        run_sweep(0, 3'd1, 1, 0, 17, 0);   // start during DONE
        run_sweep(0, 3'd2, 2, 0, 0, 1);    // abort together with start
        run_sweep(1, 3'd2, 10, 0, 0, 0);   // XOR vs inverted XOR, no settle
        run_sweep(1, 3'd5, 2, 0, 0, 0);

        // Reset mid-sweep clears everything at once and yields no done.
        @(negedge clk) drv(1, 1'b1, 1'b0, 3'd2);
        @(posedge clk); #1 drv(1, 1'b0, 1'b0, 3'd2);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        sample(1, o); chk("midrun_reset_b", 32'(o), 0);
        sample(0, o); chk("midrun_reset_a", 32'(o), 0);
        @(negedge clk) rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            sample(1, o);
            if (o.done || o.busy || o.in0 || o.in1) dcount++;
        end
        chk("after_reset_idle", dcount, 0);

        for (int n = 0; n < 30; n++) begin
            w   = int'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            per = ((w == 0) ? S_A : S_B) + 2;
            lat = (sel < 3'd6) ? 4 * per + 1 : 1;
            ab_at = 0; rp_at = 0;
            if (sel < 3'd6 && $urandom_range(0, 3) == 0)
                ab_at = int'($urandom_range(0, 3)) * per + int'($urandom_range(0, per - 2)) + 1;
            else if ($urandom_range(0, 3) == 0)
                rp_at = int'($urandom_range(1, lat));
            run_sweep(w, sel, int'($urandom_range(0, 15)), ab_at, rp_at, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer that drives a 2-input combinational gate (OrGate, AndGate, etc.) through all four input vectors and checks each output against a selected truth table.
- Turns the exhaustive 00/01/10/11 sweep into a reusable self-checking hardware block for on-board or in-sim gate qualification.
- Sits between a host/start source and one gate instance; the gate's in0/in1 are driven by this block, and its out is fed back.

Parameters:
- SETTLE_CYCLES, 2, cycles to hold each vector before sampling gate_out; 0 allowed (no WAIT state); max 255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- abort  input  1  synchronous cancel of a running sweep
- gate_sel  input  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6-7 invalid
- gate_out  input  1  output of gate under test
- in0  output  1  gate input 0 (= vec[1])
- in1  output  1  gate input 1 (= vec[0])
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  one-cycle pulse when a sweep completes or is rejected
- pass  output  1  1 if all 4 vectors matched; valid from done, held until next accepted start
- fail_cnt  output  3  mismatch count, 0..4
- first_fail_vec  output  2  vector index of the first mismatch
- first_fail_valid  output  1  first_fail_vec is meaningful
- sel_err  output  1  last start had invalid gate_sel

Behaviour:
- Reset: all outputs 0; state IDLE; vec=0; counters 0.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE, start=1, valid gate_sel:
  - latch gate_sel; clear pass, fail_cnt, first_fail_*, sel_err; vec=0.
  - next state APPLY; busy=1.
- IDLE, start=1, gate_sel>=6: sel_err=1; go to DONE; pass=0.
- APPLY: in0/in1 driven from vec (registered, stable through WAIT and CHECK); 1 cycle. Next state is WAIT, or CHECK when SETTLE_CYCLES=0.
- WAIT: exactly SETTLE_CYCLES cycles; settle counter reset on entry.
- CHECK: 1 cycle; compare gate_out against expected bit.
  - On mismatch: fail_cnt+1. If first_fail_valid=0, set first_fail_vec=vec and first_fail_valid=1.
  - If vec=3, go to DONE; otherwise vec+1 and go to APPLY.
- DONE: 1 cycle; done=1; busy=0; pass=(fail_cnt==0 && !sel_err), including the CHECK result of vec 3. Returns to IDLE.
- Truth tables as 4-bit masks indexed by vec: AND 1000, OR 1110, XOR 0110, NAND 0111, NOR 0001, XNOR 1001.
- Latency:
  - start edge to done pulse = 4*(SETTLE_CYCLES+2)+1 cycles; default 17.
  - invalid sel: done one cycle after start.
- start while busy: ignored, no effect on the latched sel.
- start during the DONE cycle: ignored; accepted only in IDLE.
- abort while busy: next state IDLE, busy=0, done not pulsed, in0/in1=0, pass=0, partial fail_cnt retained. abort in IDLE or DONE: ignored.
- abort and start in the same IDLE cycle: start wins.
- gate_sel changes mid-sweep: no effect; the latched value is used.
- rst_n low mid-sweep: immediate return to reset values; no done.
- in0/in1 return to 0 in IDLE and DONE.

Decomposition:
- Shared header gate_defs.vh:
  - gate code localparams (GATE_AND..GATE_XNOR)
  - truth-table mask constants
  - state encodings
- One sub-module, gate_expect_lut: combinational; (gate_sel[2:0], vec[1:0]) -> expected, sel_valid. Reusable by other gate benches.

Test Plan:
- OR selected, gate_out wired to a real OrGate, SETTLE_CYCLES=2, start pulse -> done at cycle 17; pass=1, fail_cnt=0, first_fail_valid=0; in0/in1 sequence 00,01,10,11, each held 4 cycles.
- AND selected with OrGate attached -> done; pass=0, fail_cnt=2, first_fail_vec=01, first_fail_valid=1.
- gate_sel=7, start -> sel_err=1, done one cycle later, pass=0, busy never high, in0/in1 stay 0.
- Abort asserted while vec=2 in WAIT -> next cycle IDLE, busy=0, no done pulse; a fresh start then completes with pass=1 (OR/OrGate).
- start re-pulsed mid-sweep with gate_sel changed to NOR -> ignored; sweep completes as OR, pass=1, latency unchanged.
- SETTLE_CYCLES=0 build, XOR against an inverted-output model -> done at cycle 9, fail_cnt=4, first_fail_vec=00; rst_n pulsed mid-run in a repeat -> all outputs 0 immediately.
